// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: payload width, output FIFO geometry,
// header length field position and channel addresses.
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_PTR_W  = 5;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;

  localparam logic [1:0] CH_ADDR_0 = 2'b00;
  localparam logic [1:0] CH_ADDR_1 = 2'b01;
  localparam logic [1:0] CH_ADDR_2 = 2'b10;

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port storage array for one router output FIFO: synchronous write,
// registered read with a synchronous clear on the read register.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Clear wins over read so a flush or idle cycle always presents zero.
  always_ff @(posedge clock) begin
    if (rd_clr)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_fifo.sv
// Output-channel FIFO of the 1x3 router: pointers, flags and read-side packet
// counter. Optional sticky overflow flag is enabled by ROUTER_FIFO_OVF_EN.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int PTR_W  = FIFO_PTR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              ovf_err
);

  localparam int AW    = PTR_W - 1;
  localparam int CNT_W = 7;

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;
  logic              rd_valid_reg;
  logic [DATA_W:0]   rd_word;
  logic              flush, wr_go, rd_go, rd_clr;

  assign flush = !resetn || soft_reset;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_go = write_enb && !full && !flush;
  assign rd_go = read_enb && !empty && !flush;

  // The array read is registered, so the word read at the previous edge is
  // folded into the counter here; pkt_cnt_next is the packet count as of now.
  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (rd_valid_reg) begin
      if (rd_word[DATA_W])
        pkt_cnt_next = CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
      else if (pkt_cnt_reg != '0)
        pkt_cnt_next = pkt_cnt_reg - CNT_W'(1);
    end
  end

  assign rd_clr = flush || (!rd_go && (pkt_cnt_next == '0));

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pkt_cnt_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_go) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_go) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      pkt_cnt_reg  <= pkt_cnt_next;
      rd_valid_reg <= rd_go;
    end
  end

  router_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_go),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_en   (rd_go),
    .rd_clr  (rd_clr),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_word)
  );

  assign data_out = rd_word[DATA_W-1:0];

`ifdef ROUTER_FIFO_OVF_EN
  logic ovf_err_reg;

  // Sticky: survives soft_reset, cleared only by resetn.
  always_ff @(posedge clock) begin
    if (!resetn)
      ovf_err_reg <= 1'b0;
    else if (write_enb && full && !soft_reset)
      ovf_err_reg <= 1'b1;
  end

  assign ovf_err = ovf_err_reg;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model feeding a
// per-cycle scoreboard that a separate monitor drains and compares.
module tb_router_fifo;

`ifdef ROUTER_FIFO_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty, ovf_err;

  always #5 clock = ~clock;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .ovf_err    (ovf_err)
  );

  typedef struct {
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       rd;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] mq[$];
  int         pkt = 0;
  logic [7:0] mdout = 8'h00;
  logic       movf = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: FIFO as a queue of {header_flag, byte}, packet count as
  // the remaining bytes of the packet currently being read.
  task automatic step(input logic rstn, input logic sr, input logic we,
                      input logic re, input logic lfd, input logic [7:0] d);
    bit         was_full, was_empty, rd;
    logic [8:0] ent;
    exp_t       e;
    @(negedge clock);
    resetn = rstn; soft_reset = sr; write_enb = we;
    read_enb = re; lfd_state = lfd; data_in = d;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    rd = 1'b0;
    if (!rstn) begin
      mq.delete(); pkt = 0; mdout = 8'h00; movf = 1'b0;
    end else if (sr) begin
      mq.delete(); pkt = 0; mdout = 8'h00;
    end else begin
      if (we && was_full && OVF) movf = 1'b1;
      if (re && !was_empty) begin
        ent = mq.pop_front();
        rd = 1'b1;
        mdout = ent[7:0];
        if (ent[8]) pkt = int'(ent[7:2]) + 1;
        else if (pkt > 0) pkt = pkt - 1;
      end else if (pkt == 0) begin
        mdout = 8'h00;
      end
      if (we && !was_full) mq.push_back({lfd, d});
    end
    cyc++;
    e.dout = mdout; e.full = (mq.size() == 16); e.empty = (mq.size() == 0);
    e.ovf = movf; e.rd = rd; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("data_out", e.cyc, data_out, e.dout);
      chk("full",     e.cyc, {7'd0, full},    {7'd0, e.full});
      chk("empty",    e.cyc, {7'd0, empty},   {7'd0, e.empty});
      chk("ovf_err",  e.cyc, {7'd0, ovf_err}, {7'd0, e.ovf});
      if (e.rd) $display("cyc %0d read data_out=%h", e.cyc, data_out);
    end
  end

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
    read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
    repeat (2) step(0, 0, 0, 0, 0, 8'h00);

    // Fill to 16, drop a 17th write, drain in order.
    for (int i = 1; i <= 16; i++) step(1, 0, 1, 0, 0, 8'(i));
    step(1, 0, 1, 0, 0, 8'hFF);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);

    // Header 0D (len 3), three payload bytes, parity A5.
    step(1, 0, 1, 0, 1, 8'h0D);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 8'($urandom_range(1, 255)));
    step(1, 0, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 8'h00);
    repeat (2) step(1, 0, 0, 0, 0, 8'h00);

    // Simultaneous read/write at 15 entries and at full.
    for (int i = 0; i < 15; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 8'($urandom));
    step(1, 0, 1, 0, 0, 8'h3C);
    step(1, 0, 1, 1, 0, 8'hC3);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 1, 0, 8'h00);

    // Soft reset concurrent with a write.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 8'(8'h20 + i));
    step(1, 0, 0, 1, 0, 8'h00);
    step(1, 1, 1, 0, 0, 8'h77);
    step(1, 0, 0, 1, 0, 8'h00);
    step(1, 0, 1, 0, 0, 8'h5A);
    repeat (2) step(1, 0, 0, 1, 0, 8'h00);

    // Streaming with an 8-entry lag to wrap the pointers.
    for (int i = 0; i < 48; i++)
      step(1, 0, (i < 40), (i >= 8), 0, 8'($urandom));
    step(1, 0, 0, 0, 0, 8'h00);

    // Overflow: sticky through soft_reset, cleared by resetn.
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    step(1, 0, 1, 0, 0, 8'hEE);
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);

    // Random traffic including headers, soft resets and occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom % 200) != 0, ($urandom % 50) == 0, $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom % 8) == 0, 8'($urandom));
    repeat (3) step(1, 0, 0, 0, 0, 8'h00);

    @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain cyc=%0d got=%0d exp=0", cyc, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Output-channel FIFO of the 1x3 router. Three instances sit downstream of the synchroniser, one per destination port.
- Stores bytes written under write_enb[i], flags the header byte of each packet, and tracks packet length on the read side.
- Reports full/empty back to the synchroniser and flushes itself on that channel's soft_reset timeout.

Parameters:
- DATA_W, 8, payload byte width
- DEPTH, 16, entries (power of two)
- PTR_W, 5, log2(DEPTH)+1; the MSB is the wrap bit

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous flush from the synchroniser timeout
- write_enb  in  1  write request from the synchroniser (one bit of write_enb[2:0])
- read_enb  in  1  read request from the destination
- lfd_state  in  1  high while data_in carries the header byte
- data_in  in  DATA_W  byte from the router register stage
- data_out  out  DATA_W  registered read data
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- ovf_err  out  1  sticky overflow flag; active only with the optional feature

Behaviour:
- Reset uses resetn, synchronous, active-low, on clock.
- Reset values: data_out=0, full=0, empty=1, ovf_err=0, wr_ptr=rd_ptr=0, pkt_cnt=0. Memory contents are not reset.
- Storage: DEPTH x (DATA_W+1). Bit DATA_W holds the lfd_state value captured with the byte.
- Write: when write_enb && !full, mem[wr_ptr[PTR_W-2:0]] <= {lfd_state, data_in} and wr_ptr++.
- Write while full: ignored; no pointer change.
- Read: when read_enb && !empty, data_out <= mem[rd_ptr][DATA_W-1:0] and rd_ptr++. One-cycle latency: the byte is visible the cycle after read_enb is sampled.
- Read while empty: ignored; data_out holds its value.
- Status flags are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr)
  - full = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal)
- Pointers wrap naturally at 2*DEPTH.
- Simultaneous read and write:
  - Both proceed when neither flag blocks them; occupancy is unchanged.
  - When full, the read proceeds and the write is dropped, because full is evaluated before the edge.
  - When empty, only the write proceeds.
- Packet counter pkt_cnt (7 bits) tracks the current packet on the read side:
  - Reading an entry with the header flag set: pkt_cnt <= data[7:2] + 1 (payload length plus parity).
  - Reading a non-header entry with pkt_cnt != 0: pkt_cnt--.
  - When pkt_cnt == 0 and no read occurs: data_out <= 0 (idle channel reads zero).
  - When pkt_cnt != 0 and no read occurs: data_out holds.
- Soft reset: soft_reset=1 forces wr_ptr=rd_ptr=0, pkt_cnt=0, data_out=0 at the next edge.
  - Any write or read in the same cycle is discarded.
  - empty=1 the following cycle.
  - ovf_err is NOT cleared by soft_reset; only resetn clears it.
- resetn has priority over soft_reset, and soft_reset has priority over read and write.
- Reset mid-packet: all packet state is lost, and the next header read restarts counting.

Optional Feature:
- Macro ROUTER_FIFO_OVF_EN.
- Defined: ovf_err sets to 1 on any cycle with write_enb && full && !soft_reset. It stays set until resetn.
- Undefined: ovf_err is tied to 0 and no overflow logic is synthesised.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W, FIFO_DEPTH, FIFO_PTR_W
  - HDR_LEN_MSB=7, HDR_LEN_LSB=2
  - the channel-address constants 2'b00 / 2'b01 / 2'b10
- One sub-module: router_fifo_mem, a registered-read dual-port array of DEPTH x (DATA_W+1), with a synchronous write port and a read port.
- The pointer, flag and counter logic stays in router_fifo.

Test Plan:
1. Reset, then write 16 bytes 8'h01..8'h10 with lfd_state=0 -> full=1 after the 16th edge and empty=0. A 17th write of 8'hFF is dropped, and reading all 16 returns 01..10 in order.
2. Write header 8'h0D (len 3, addr 01) with lfd_state=1, then 3 payload bytes and parity 8'hA5; read 5 bytes -> data_out sequence 0D,p0,p1,p2,A5. pkt_cnt goes 4,3,2,1,0, then data_out=0 on the next idle cycle.
3. Fill to 15 entries, then assert read_enb and write_enb together for 4 cycles -> occupancy stays 15 and full stays 0. With the FIFO full, a simultaneous read and write leaves occupancy at 15.
4. Write 5 bytes, pulse soft_reset for one cycle concurrent with a write -> empty=1 and data_out=0 the next cycle, and the concurrent write is not stored.
5. Stream 40 writes with reads lagging by 8 entries -> pointer wrap is exercised, and data is read back in order with no spurious full or empty.
6. With ROUTER_FIFO_OVF_EN defined: fill to 16, write once more -> ovf_err=1 and it persists through soft_reset. Asserting resetn=0 clears it. Without the macro, ovf_err stays 0.
